// File: rtl/control_regfile_if.sv
// Host byte-stream link between a first-word-fall-through byte FIFO and its consumer.
// Latency: none, wires only.
// Backpressure: the consumer pops with data_clk; data is held while data_rdy=1.
//
// Signals:
//   data      byte at the FIFO head, valid while data_rdy=1
//   data_rdy  FIFO holds at least one byte
//   data_clk  one-cycle pop strobe from the consumer
interface control_regfile_if;
  logic [7:0] data;
  logic       data_rdy;
  logic       data_clk;

  modport master (output data, output data_rdy, input data_clk);
  modport slave  (input data, input data_rdy, output data_clk);
endinterface

// File: rtl/control_regfile.sv
// Deframes host bytes (SYNC, CMD, data MSB first, XOR CSUM) into shadow registers; commit copies shadow to active.
// Latency: regs/commit_pulse/frame_err update two edges after the CSUM byte is popped.
// Backpressure: pops at most every other cycle, only while data_rdy=1, never during the apply cycle.
//
// Ports:
//   clk_100M, rst_n      clock and async active-low reset (deassertion synchronised here)
//   host (slave)         byte stream: data, data_rdy in; data_clk pop strobe out
//   regs                 active registers, register k at [k*W +: W], W = REG_BYTES*8
//   commit_pulse         one cycle after a committing frame is applied
//   frame_err            one cycle after a rejected or timed-out frame
//   err_count            saturating count of rejected frames
module control_regfile #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned REG_BYTES   = 3,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VAL = '0
) (
  input  logic                            clk_100M,
  input  logic                            rst_n,
  control_regfile_if.slave                host,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs,
  output logic                            commit_pulse,
  output logic                            frame_err,
  output logic [15:0]                     err_count
);

  localparam int unsigned W  = REG_BYTES * 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IW = $clog2(REG_BYTES + 1);

  typedef enum logic [2:0] {HUNT, CMD, DATA, CSUM, APPLY} state_t;

  logic [1:0]            rst_sync_q;
  logic                  rst_sync_n;
  state_t                state;
  logic [7:0]            cmd_q;
  logic [7:0]            csum_q;
  logic [IW-1:0]         idx_q;
  logic [W-1:0]          asm_q;
  logic                  csum_ok_q;
  logic                  addr_ok_q;
  logic [TW-1:0]         timer_q;
  logic                  popped_q;
  logic [NUM_REGS*W-1:0] shadow;

  logic                  pop;
  logic                  in_frame;
  logic                  timeout_hit;
  logic                  addr_ok;
  logic                  frame_ok;
  logic                  bump_err;
  logic [6:0]            addr;
  logic [15:0]           err_nx;
  logic [NUM_REGS*W-1:0] shadow_nx;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  // The pop strobe is combinational so it can never fire on a cycle where
  // data_rdy has dropped. popped_q resets to 1, which also holds it low in reset.
  assign host.data_clk = host.data_rdy && !popped_q && (state != APPLY);
  assign pop           = host.data_clk;

  assign addr        = cmd_q[6:0];
  assign addr_ok     = (32'(addr) < NUM_REGS);
  assign in_frame    = (state == CMD) || (state == DATA) || (state == CSUM);
  assign timeout_hit = in_frame && !pop && (timer_q == TW'(TIMEOUT_CYC - 1));
  assign frame_ok    = csum_ok_q && addr_ok_q;
  assign bump_err    = ((state == APPLY) && !frame_ok) || timeout_hit;
  assign err_nx      = (bump_err && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

  // Shadow array with the assembled value merged in; commits load regs from this
  // so the new value and the rest of the shadow appear on the same edge.
  always_comb begin
    shadow_nx = shadow;
    if (addr_ok) shadow_nx[32'(addr)*W +: W] = asm_q;
  end

  always_ff @(posedge clk_100M or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state        <= HUNT;
      cmd_q        <= '0;
      csum_q       <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      csum_ok_q    <= 1'b0;
      addr_ok_q    <= 1'b0;
      timer_q      <= '0;
      popped_q     <= 1'b1;
      shadow       <= RESET_VAL;
      regs         <= RESET_VAL;
      commit_pulse <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
    end else begin
      popped_q     <= pop;
      commit_pulse <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= err_nx;
      // Idle cycles count only inside a frame; any pop restarts the count.
      timer_q      <= (in_frame && !pop && !timeout_hit) ? timer_q + 1'b1 : '0;

      case (state)
        HUNT: begin
          if (pop && (host.data == SYNC_BYTE)) state <= CMD;
        end
        CMD: begin
          if (pop) begin
            cmd_q  <= host.data;
            csum_q <= host.data;
            idx_q  <= '0;
            state  <= DATA;
          end else if (timeout_hit) begin
            state     <= HUNT;
            frame_err <= 1'b1;
          end
        end
        DATA: begin
          if (pop) begin
            asm_q  <= (asm_q << 8) | W'(host.data);
            csum_q <= csum_q ^ host.data;
            idx_q  <= idx_q + 1'b1;
            if (idx_q == IW'(REG_BYTES - 1)) state <= CSUM;
          end else if (timeout_hit) begin
            state     <= HUNT;
            frame_err <= 1'b1;
          end
        end
        CSUM: begin
          if (pop) begin
            csum_ok_q <= (csum_q == host.data);
            addr_ok_q <= addr_ok;
            state     <= APPLY;
          end else if (timeout_hit) begin
            state     <= HUNT;
            frame_err <= 1'b1;
          end
        end
        APPLY: begin
          state <= HUNT;
          if (frame_ok) begin
            shadow <= shadow_nx;
            if (cmd_q[7]) begin
              regs         <= shadow_nx;
              commit_pulse <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_regfile.sv
module tb_control_regfile;
  localparam int NR = 8;
  localparam int RB = 3;
  localparam int TO = 100;
  localparam int W  = RB * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  control_regfile_if bus();
  logic [NR*W-1:0] regs;
  logic            commit_pulse;
  logic            frame_err;
  logic [15:0]     err_count;

  control_regfile #(.NUM_REGS(NR), .REG_BYTES(RB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk_100M(clk), .rst_n(rst_n), .host(bus),
    .regs(regs), .commit_pulse(commit_pulse), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] txq[$];
  int rdy_pct = 70;

  // Frame-level reference model
  logic [W-1:0] mshadow[NR];
  logic [W-1:0] mregs[NR];
  logic [15:0]  merr;
  bit           m_in_frame;
  logic [7:0]   fb[$];
  int           idle;
  bit           ev_pending;
  int           ev_cycle;
  bit           ev_ok;
  bit           ev_commit;
  int           ev_addr;
  logic [W-1:0] ev_val;
  int           cyc = 0;
  int           n_commit = 0;
  int           n_ferr = 0;
  bit           prev_dclk = 0;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      mshadow[k] = '0;
      mregs[k]   = '0;
    end
    merr       = '0;
    m_in_frame = 0;
    fb.delete();
    idle       = 0;
    ev_pending = 0;
  endtask

  function automatic logic [NR*W-1:0] mflat();
    logic [NR*W-1:0] f;
    for (int k = 0; k < NR; k++) f[k*W +: W] = mregs[k];
    return f;
  endfunction

  // FWFT source: head byte presented with random throttling
  initial begin
    bus.data     = 8'h00;
    bus.data_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (txq.size() > 0 && int'($urandom_range(0, 99)) < rdy_pct) begin
        bus.data_rdy = 1'b1;
        bus.data     = txq[0];
      end else begin
        bus.data_rdy = 1'b0;
        bus.data     = 8'($urandom);
      end
    end
  end

  // Compare process: checks every cycle, then advances the model with this cycle's pop
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_regs", 192'(regs), 192'(0));
        chk("rst_commit", 192'(commit_pulse), 192'(0));
        chk("rst_ferr", 192'(frame_err), 192'(0));
        chk("rst_errcnt", 192'(err_count), 192'(0));
        chk("rst_dclk", 192'(bus.data_clk), 192'(0));
        prev_dclk = 0;
      end else begin
        bit exp_c;
        bit exp_f;
        exp_c = 0;
        exp_f = 0;
        if (ev_pending && ev_cycle == cyc) begin
          ev_pending = 0;
          if (ev_ok) begin
            mshadow[ev_addr] = ev_val;
            if (ev_commit) begin
              for (int k = 0; k < NR; k++) mregs[k] = mshadow[k];
              exp_c = 1;
            end
          end else begin
            if (merr != 16'hFFFF) merr = merr + 16'd1;
            exp_f = 1;
          end
        end
        chk("regs", 192'(regs), 192'(mflat()));
        chk("err_count", 192'(err_count), 192'(merr));
        chk("commit_pulse", 192'(commit_pulse), 192'(exp_c));
        chk("frame_err", 192'(frame_err), 192'(exp_f));
        chk("dclk_without_rdy", 192'(bus.data_clk && !bus.data_rdy), 192'(0));
        chk("dclk_back_to_back", 192'(bus.data_clk && prev_dclk), 192'(0));
        if (commit_pulse) n_commit++;
        if (frame_err) n_ferr++;
        if (bus.data_clk && bus.data_rdy) begin
          logic [7:0] b;
          b = bus.data;
          if (txq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_empty got=%h exp=no_pop", b);
          end else begin
            chk("pop_byte", 192'(b), 192'(txq[0]));
            void'(txq.pop_front());
          end
          if (!m_in_frame) begin
            if (b == 8'hA5) begin
              m_in_frame = 1;
              fb.delete();
              idle = 0;
            end
          end else begin
            fb.push_back(b);
            idle = 0;
            if (fb.size() == RB + 2) begin
              logic [7:0] x;
              x          = fb[0] ^ fb[1] ^ fb[2] ^ fb[3];
              ev_addr    = int'(fb[0][6:0]);
              ev_val     = {fb[1], fb[2], fb[3]};
              ev_commit  = fb[0][7];
              ev_ok      = (x == fb[4]) && (ev_addr < NR);
              ev_cycle   = cyc + 2;
              ev_pending = 1;
              m_in_frame = 0;
            end
          end
        end else if (m_in_frame) begin
          idle++;
          if (idle == TO) begin
            ev_ok      = 0;
            ev_cycle   = cyc + 1;
            ev_pending = 1;
            m_in_frame = 0;
          end
        end
        prev_dclk = bus.data_clk;
      end
      cyc++;
    end
  end

  task automatic put(input logic [63:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) txq.push_back(bytes[8*i +: 8]);
  endtask

  task automatic frame(input int addr, input bit commit, input logic [23:0] val, input bit bad);
    logic [7:0] cmd;
    logic [7:0] cs;
    cmd = {commit, 7'(addr)};
    cs  = cmd ^ val[23:16] ^ val[15:8] ^ val[7:0];
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    put({16'h0, 8'hA5, cmd, val, cs}, 6);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((txq.size() != 0 || m_in_frame || ev_pending) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_done got=stuck exp=idle", name);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int f0;
    int n;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_errcnt_lit", 192'(err_count), 192'(0));
    chk("reset_regs_lit", 192'(regs), 192'(0));

    // 1: shadow-only write, then commit of another register
    c0 = n_commit; f0 = n_ferr;
    put(64'hA5_02_12_34_56_72, 6);
    wait_done("t1a");
    chk("t1a_commits", 192'(n_commit - c0), 192'(0));
    chk("t1a_ferr", 192'(n_ferr - f0), 192'(0));
    chk("t1a_regs_lit", 192'(regs), 192'(0));
    put(64'hA5_80_00_00_01_81, 6);
    wait_done("t1b");
    chk("t1b_commits", 192'(n_commit - c0), 192'(1));
    chk("t1b_reg0_lit", 192'(regs[23:0]), 192'(24'h000001));
    chk("t1b_reg2_lit", 192'(regs[71:48]), 192'(24'h123456));

    // 2: bad checksum, then a commit shows register 3 untouched
    f0 = n_ferr;
    put(64'hA5_03_AA_BB_CC_00, 6);
    wait_done("t2a");
    chk("t2_ferr", 192'(n_ferr - f0), 192'(1));
    chk("t2_errcnt_lit", 192'(err_count), 192'(1));
    put(64'hA5_80_00_00_01_81, 6);
    wait_done("t2b");
    chk("t2_reg3_lit", 192'(regs[95:72]), 192'(0));

    // 3: out-of-range address with commit flag
    c0 = n_commit; f0 = n_ferr;
    put(64'hA5_88_00_00_05_8D, 6);
    wait_done("t3");
    chk("t3_ferr", 192'(n_ferr - f0), 192'(1));
    chk("t3_commits", 192'(n_commit - c0), 192'(0));
    chk("t3_errcnt_lit", 192'(err_count), 192'(2));

    // 4: noise and heavy throttling
    rdy_pct = 40;
    f0 = n_ferr;
    put(64'h00_FF_A5_81_00_00_07_86, 8);
    wait_done("t4");
    chk("t4_ferr", 192'(n_ferr - f0), 192'(0));
    chk("t4_reg1_lit", 192'(regs[47:24]), 192'(24'h000007));
    rdy_pct = 70;

    // Sync byte as payload
    put(64'hA5_82_A5_A5_A5_27, 6);
    wait_done("sync_payload");
    chk("sync_payload_reg2_lit", 192'(regs[71:48]), 192'(24'hA5A5A5));

    // 5: inter-byte timeout, then a good frame is accepted
    f0 = n_ferr;
    put(64'hA5_01_11, 3);
    wait_done("t5a");
    chk("t5_ferr", 192'(n_ferr - f0), 192'(1));
    chk("t5_errcnt_lit", 192'(err_count), 192'(3));
    put(64'hA5_84_00_00_09_8D, 6);
    wait_done("t5b");
    chk("t5_reg4_lit", 192'(regs[119:96]), 192'(24'h000009));

    // Random frames with noise, random throttling, some bad and out-of-range
    for (int i = 0; i < 40; i++) begin
      rdy_pct = int'($urandom_range(30, 100));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        txq.push_back(nb);
      end
      frame(int'($urandom_range(0, 9)), 1'($urandom), 24'($urandom), $urandom_range(0, 4) == 0);
      wait_done("rand");
    end
    rdy_pct = 70;

    // 6: reset mid-DATA after committed writes
    put(64'hA5_05_01_02_03_05, 6);
    n = 0;
    while (!(m_in_frame && fb.size() >= 2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_data", 192'(n < 2000), 192'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_regs_lit", 192'(regs), 192'(0));
    chk("t6_async_commit_lit", 192'(commit_pulse), 192'(0));
    chk("t6_async_ferr_lit", 192'(frame_err), 192'(0));
    chk("t6_async_errcnt_lit", 192'(err_count), 192'(0));
    chk("t6_async_dclk_lit", 192'(bus.data_clk), 192'(0));
    txq.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    put(64'hA5_86_00_00_0A_8C, 6);
    wait_done("t6a");
    chk("t6_regs_lit", 192'(regs), 192'(24'h00000A) << 144);

    // Saturation of err_count
    @(posedge clk);
    #2 force dut.err_count = 16'hFFFE;
    merr = 16'hFFFE;
    @(posedge clk);
    #2 release dut.err_count;
    put(64'hA5_03_AA_BB_CC_00, 6);
    wait_done("t6b");
    chk("t6_sat1_lit", 192'(err_count), 192'(16'hFFFF));
    put(64'hA5_03_AA_BB_CC_00, 6);
    wait_done("t6c");
    chk("t6_sat2_lit", 192'(err_count), 192'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_regfile.md
Name: control_regfile

Overview:
- Parametrised successor to the fixed-field scanner control block. It deframes the host byte stream into a generic array of NUM_REGS registers, each REG_BYTES wide.
- Adds sync-byte framing, XOR checksum, out-of-range address rejection, an inter-byte timeout, and shadow/active double-buffering with atomic commit.
- Sits between the host byte FIFO (data/data_rdy/data_clk) and the scan engine, AFE DACs, motor and LED blocks, which consume the active registers.

Parameters:
- NUM_REGS, 8, number of registers; address range 0..NUM_REGS-1, NUM_REGS <= 128.
- REG_BYTES, 3, bytes per register; register width is REG_BYTES*8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 100000, maximum idle cycles between bytes inside a frame.
- RESET_VAL, all zeros, [NUM_REGS*REG_BYTES*8] reset/initial contents of the shadow and active arrays.

Ports:
- clk_100M  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- data  in  8  byte from the host FIFO; valid while data_rdy=1 (first-word-fall-through).
- data_rdy  in  1  source holds at least one byte.
- data_clk  out  1  one-cycle pop strobe.
- regs  out  NUM_REGS*REG_BYTES*8  active registers, flat; register k occupies [k*W +: W], where W=REG_BYTES*8.
- commit_pulse  out  1  one-cycle pulse when shadow is copied to active.
- frame_err  out  1  one-cycle pulse on any rejected frame.
- err_count  out  16  saturating count of rejected frames.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_clk=0, commit_pulse=0, frame_err=0, err_count=0.
  - shadow=RESET_VAL, regs=RESET_VAL, FSM=HUNT, timer=0.
  - Deassertion is synchronised internally.
- Byte handshake:
  - A byte is consumed in the cycle data_clk=1 while data_rdy=1; data is sampled in that same cycle.
  - data_clk is asserted only when data_rdy=1 and the FSM needs a byte.
  - data_clk is never high on two consecutive cycles, so throughput is at most one byte per 2 cycles.
  - data_clk is never asserted in APPLY.
- Frame format: SYNC_BYTE, CMD, then REG_BYTES data bytes MSB first, then CSUM.
  - CMD[7] = commit flag; CMD[6:0] = address.
  - CSUM = XOR of CMD and all data bytes. SYNC_BYTE is not included.
- FSM:
  - HUNT: consume bytes. On SYNC_BYTE go to CMD; any other byte is dropped silently, with no error.
  - CMD: latch the command byte, clear byte index, go to DATA.
  - DATA: shift bytes into a W-bit assembly register. After REG_BYTES bytes go to CSUM.
  - CSUM: go to APPLY, carrying the checksum-match and address-in-range results.
  - APPLY (one cycle, no pop), then go to HUNT:
    - If the address is >= NUM_REGS or the checksum mismatches: pulse frame_err; increment err_count, saturating at 16'hFFFF; leave shadow and regs untouched.
    - Otherwise write shadow[addr].
    - If valid and CMD[7]=1, also load regs from the whole shadow array including the new value (regs = updated shadow in the same edge). commit_pulse=1 during the following cycle.
    - A rejected frame never commits, even if CMD[7]=1.
- Timeout:
  - In CMD/DATA/CSUM the timer counts cycles since the last consumed byte.
  - On reaching TIMEOUT_CYC: abort to HUNT, pulse frame_err, increment err_count. Partial data is discarded.
  - Any pop clears the timer. The timer is held at 0 in HUNT and APPLY.
- A SYNC_BYTE value inside CMD/DATA/CSUM is treated as payload. There is no resync mid-frame.
- Reset mid-frame: the partial frame is lost and regs return to RESET_VAL.
- Output timing: regs changes only on a commit edge. frame_err and commit_pulse are never both high.

Test Plan (NUM_REGS=8, REG_BYTES=3, TIMEOUT_CYC=100):
1. Shadow-only write: send A5 02 12 34 56 72 -> no frame_err, no commit_pulse; regs stays all zeros. Then send A5 80 00 00 01 81 -> single commit_pulse; regs[0]=24'h000001 and regs[2]=24'h123456 appear on the same edge.
2. Bad checksum: send A5 03 AA BB CC 00 -> frame_err pulses once, err_count=1; a subsequent commit shows regs[3]=0.
3. Out-of-range with commit: send A5 88 00 00 05 8D (address 8, correct checksum) -> frame_err, err_count increments, no commit_pulse, regs unchanged.
4. Noise and throttling: send 00 FF A5 81 00 00 07 86 with data_rdy toggled randomly -> noise bytes dropped with no error; regs[1]=7; data_clk is never high on two consecutive cycles and never high while data_rdy=0.
5. Timeout: send A5 01 11 then hold data_rdy=0 for 100 cycles -> frame_err, err_count+1, FSM back in HUNT. A following good frame is accepted.
6. Reset: pulse rst_n low mid-DATA after a committed write -> all outputs reset immediately (asynchronously); the next complete frame decodes correctly. Force err_count to 16'hFFFF and send a bad frame -> err_count stays 16'hFFFF.
